res_bank_buffer: RTL

Multi-bank result buffer between the ModExp datapath and the host readout path, replacing the single-port, always-writing result RAM.
- Writer pushes exactly WORDS words per result into the current bank.
- A full bank is streamed out on a valid/ready interface while the writer fills the next bank (ping-pong for NUM_BANKS=2).
- Storage is simple-dual-port block RAM with registered read output.

---
 rtl/res_bank_buffer_pkg.sv | 21 ++
 rtl/res_bank_buffer_sdp_ram.sv | 23 ++
 rtl/res_bank_buffer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/res_bank_buffer_pkg.sv
// Shared defaults and reader state type for the multi-bank ModExp result buffer.
package res_bank_buffer_pkg;

  localparam int unsigned RES_DATA_WIDTH = 32;
  localparam int unsigned RES_WORDS      = 128;
  localparam int unsigned RES_ADDR_WIDTH = 7;
  localparam int unsigned RES_BANKS      = 2;
  localparam int unsigned RES_OBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_STREAM = 2'd1,
    R_FLUSH  = 2'd2
  } rd_state_e;

  // Index width that stays at least one bit wide for single-entry structures.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/res_bank_buffer_sdp_ram.sv
// Simple dual-port result RAM: one write port, one read port with registered q
// (one cycle read latency, same behaviour as the altsyncram DUAL_PORT build).
module res_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clock) begin
    if (wren) mem[wraddress] <= data;
    if (rden) q <= mem[rdaddress];
  end

endmodule

// File: rtl/res_bank_buffer.sv
// Multi-bank result buffer: writer fills whole banks, reader streams full banks
// through a small credit-controlled output FIFO on a valid/ready interface.
module res_bank_buffer
  import res_bank_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RES_DATA_WIDTH,
  parameter int unsigned WORDS      = RES_WORDS,
  parameter int unsigned ADDR_WIDTH = RES_ADDR_WIDTH,
  parameter int unsigned NUM_BANKS  = RES_BANKS,
  parameter int unsigned OBUF_DEPTH = RES_OBUF_DEPTH,
  localparam int unsigned BANK_W    = idx_width(NUM_BANKS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [2:0]            full_count
);

  localparam int unsigned PTR_W  = idx_width(OBUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned RAM_AW = BANK_W + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(OBUF_DEPTH - 1);
  localparam logic [CNT_W:0]        CREDITS   = (CNT_W + 1)'(OBUF_DEPTH);

  typedef struct packed {
    logic                  last;
    logic [BANK_W-1:0]     bank;
    logic [DATA_WIDTH-1:0] data;
  } obuf_entry_t;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  rd_state_e              state_q, state_d;
  logic [NUM_BANKS-1:0]   full_q, full_d;
  logic [BANK_W-1:0]      wbank_q, wbank_d, rbank_q, rbank_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
  logic [2:0]             fcnt_q, fcnt_d;
  logic                   pend_q, pend_d, pend_last_q, pend_last_d;
  logic [BANK_W-1:0]      pend_bank_q, pend_bank_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  obuf_entry_t            fifo_mem [OBUF_DEPTH];
  obuf_entry_t            head;
  logic [DATA_WIDTH-1:0]  ram_q;
  logic                   wr_fire, ram_wren, rd_issue, rd_pop, fifo_push;
  logic                   bank_fill, bank_release;

  assign wr_ready   = !reset && !full_q[wbank_q];
  assign rd_valid   = (count_q != '0);
  assign head       = fifo_mem[head_q];
  assign rd_data    = rd_valid ? head.data : '0;
  assign rd_last    = rd_valid & head.last;
  assign rd_bank    = rd_valid ? head.bank : '0;
  assign full_count = fcnt_q;
  assign fifo_push  = pend_q;

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wbank_d      = wbank_q;
    waddr_d      = waddr_q;
    rbank_d      = rbank_q;
    raddr_d      = raddr_q;
    fcnt_d       = fcnt_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    rd_issue     = 1'b0;
    bank_fill    = 1'b0;
    bank_release = 1'b0;
    wr_fire      = wr_valid && wr_ready;
    rd_pop       = rd_valid && rd_ready;
    ram_wren     = wr_fire && !clear;

    if (wr_fire) begin
      waddr_d = waddr_q + 1'b1;
      if (waddr_q == LAST_ADDR) begin
        waddr_d   = '0;
        bank_fill = 1'b1;
        wbank_d   = next_bank(wbank_q);
      end
    end

    unique case (state_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = R_STREAM;
          raddr_d = '0;
        end
      end
      R_STREAM: begin
        // Reserve a FIFO slot for every read still travelling through the RAM.
        if ((CNT_W + 1)'(count_q) + (CNT_W + 1)'(pend_q) < CREDITS) begin
          rd_issue = 1'b1;
          raddr_d  = raddr_q + 1'b1;
          if (raddr_q == LAST_ADDR) state_d = R_FLUSH;
        end
      end
      R_FLUSH: begin
        if (rd_pop && head.last) begin
          bank_release = 1'b1;
          rbank_d      = next_bank(rbank_q);
          state_d      = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase

    if (bank_fill)    full_d[wbank_q] = 1'b1;
    if (bank_release) full_d[rbank_q] = 1'b0;

    unique case ({bank_fill, bank_release})
      2'b10:   fcnt_d = fcnt_q + 3'd1;
      2'b01:   fcnt_d = fcnt_q - 3'd1;
      default: fcnt_d = fcnt_q;
    endcase

    pend_d      = rd_issue;
    pend_last_d = (raddr_q == LAST_ADDR);
    pend_bank_d = rbank_q;

    if (fifo_push) tail_d = next_ptr(tail_q);
    if (rd_pop)    head_d = next_ptr(head_q);
    count_d = count_q + CNT_W'(fifo_push) - CNT_W'(rd_pop);

    if (clear) begin
      state_d  = R_IDLE;
      full_d   = '0;
      wbank_d  = '0;
      waddr_d  = '0;
      rbank_d  = '0;
      raddr_d  = '0;
      fcnt_d   = '0;
      pend_d   = 1'b0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      rd_issue = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= R_IDLE;
      full_q      <= '0;
      wbank_q     <= '0;
      waddr_q     <= '0;
      rbank_q     <= '0;
      raddr_q     <= '0;
      fcnt_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_bank_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      waddr_q     <= waddr_d;
      rbank_q     <= rbank_d;
      raddr_q     <= raddr_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      pend_bank_q <= pend_bank_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[tail_q] <= '{last: pend_last_q, bank: pend_bank_q, data: ram_q};
  end

  res_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(RAM_AW)
  ) u_ram (
    .clock     (clock),
    .wren      (ram_wren),
    .wraddress ({wbank_q, waddr_q}),
    .data      (wr_data),
    .rden      (rd_issue),
    .rdaddress ({rbank_q, raddr_q}),
    .q         (ram_q)
  );

endmodule
